// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/subtract, iterative shift-add multiply and
// restoring divide, with a one-cycle done pulse and a sticky divide-by-zero flag.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           opcode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // One shift-add step: accumulate the multiplicand when the current multiplier bit is set.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [2*WIDTH-1:0] mcand,
        input logic               mbit
    );
        logic [2*WIDTH-1:0] addend;
        if (mbit) begin
            addend = mcand;
        end else begin
            addend = ZERO_2W;
        end
        mul_step = acc + addend;
    endfunction

    // One restoring-divide step on {remainder, dividend/quotient}; shifted value needs WIDTH+1 bits.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   dvsr
    );
        logic [WIDTH:0]   shifted;
        logic [WIDTH+1:0] diff;
        logic [WIDTH-1:0] rem;
        logic             qbit;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvsr};
        if (diff[WIDTH+1]) begin
            rem  = shifted[WIDTH-1:0];
            qbit = 1'b0;
        end else begin
            rem  = diff[WIDTH-1:0];
            qbit = 1'b1;
        end
        div_step = {rem, acc[WIDTH-2:0], qbit};
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div_zero_q, div_zero_d;
    logic                 busy_q, done_q;

    // Next-state, datapath iteration and operation acceptance.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mcand_d    = mcand_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_CALC: begin
                if (op_q == OP_MUL) begin
                    acc_d   = mul_step(acc_q, mcand_q, b_q[0]);
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                end else begin
                    acc_d   = div_step(acc_q, b_q);
                end
                if (cnt_q == CNT_LAST) begin
                    result_d   = acc_d;
                    div_zero_d = 1'b0;
                    cnt_d      = CNT_ZERO;
                    state_d    = S_FIN;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                    state_d    = S_CALC;
                end
            end
            S_IDLE, S_FIN: begin
                if (start) begin
                    op_d    = opcode;
                    mcand_d = {ZERO_W, A};
                    b_d     = B;
                    cnt_d   = CNT_ZERO;
                    // Add/subtract and divide-by-zero finish at the accepting edge itself.
                    case (opcode)
                        OP_ADD: begin
                            result_d   = {ZERO_W, A} + {ZERO_W, B};
                            div_zero_d = 1'b0;
                            state_d    = S_FIN;
                        end
                        OP_SUB: begin
                            result_d   = {ZERO_W, A} - {ZERO_W, B};
                            div_zero_d = 1'b0;
                            state_d    = S_FIN;
                        end
                        OP_MUL: begin
                            acc_d   = ZERO_2W;
                            state_d = S_CALC;
                        end
                        OP_DIV: begin
                            if (B == ZERO_W) begin
                                result_d   = ZERO_2W;
                                div_zero_d = 1'b1;
                                state_d    = S_FIN;
                            end else begin
                                acc_d   = {ZERO_W, A};
                                state_d = S_CALC;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, iteration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            mcand_q    <= ZERO_2W;
            b_q        <= ZERO_W;
            acc_q      <= ZERO_2W;
            cnt_q      <= CNT_ZERO;
            result_q   <= ZERO_2W;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mcand_q    <= mcand_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            busy_q     <= (state_d == S_CALC);
            done_q     <= (state_d == S_FIN);
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): stimulus pushes expectations, a monitor
// pops and checks result, div_zero, completion cycle and busy length on each done.
module tb_seq_alu;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     opcode;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;
    logic           div_zero;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          cyc;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_run = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run = busy_run + 1;
            if (done) begin
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("div_zero", 32'(div_zero), 32'(e.dz));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_run, e.busy_cycles);
                end
                busy_run = 0;
            end
        end
    end

    // Drive one request for a single cycle; operands are scrambled afterwards to prove capture.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] er, input logic ed, input int extra, input bit push);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        A      = a;
        B      = b;
        if (push) begin
            e.res = er;
            e.dz = ed;
            e.cyc = cyc + 1 + extra;
            e.busy_cycles = extra;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        B     = ~b;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 2'b00;
        A      = 8'd0;
        B      = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        rst_n = 1'b1;

        issue(2'b00, 8'd255, 8'd255, 16'd510,   1'b0, 0, 1'b1); drain();
        issue(2'b11, 8'd5,   8'd9,   16'd65532, 1'b0, 0, 1'b1); drain();
        issue(2'b11, 8'd9,   8'd5,   16'd4,     1'b0, 0, 1'b1); drain();
        issue(2'b11, 8'd0,   8'd255, 16'd65281, 1'b0, 0, 1'b1); drain();

        // Multiply with start pulses during busy that must be ignored.
        issue(2'b01, 8'd200, 8'd150, 16'd30000, 1'b0, 8, 1'b1);
        start = 1'b1; opcode = 2'b00; A = 8'd1; B = 8'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("hold_result", 32'(result), 32'd30000);

        issue(2'b01, 8'd255, 8'd255, 16'd65025, 1'b0, 8, 1'b1); drain();
        issue(2'b10, 8'd200, 8'd7,   16'd1052,  1'b0, 8, 1'b1); drain();
        issue(2'b10, 8'd7,   8'd0,   16'd0,     1'b1, 0, 1'b1); drain();
        repeat (2) @(negedge clk);
        chk("hold_dz", 32'(div_zero), 32'd1);
        issue(2'b00, 8'd1,   8'd2,   16'd3,     1'b0, 0, 1'b1); drain();
        issue(2'b10, 8'd255, 8'd1,   16'd255,   1'b0, 8, 1'b1); drain();
        issue(2'b10, 8'd5,   8'd9,   16'd1280,  1'b0, 8, 1'b1); drain();

        // Back-to-back: start held through the multiply, next op accepted in FIN.
        @(negedge clk);
        start = 1'b1; opcode = 2'b01; A = 8'd12; B = 8'd13;
        e.res = 16'd156; e.dz = 1'b0; e.cyc = cyc + 9; e.busy_cycles = 8;
        sb.push_back(e);
        repeat (9) @(negedge clk);
        chk("b2b_fin_done", 32'(done), 32'd1);
        opcode = 2'b00; A = 8'd1; B = 8'd2;
        e.res = 16'd3; e.dz = 1'b0; e.cyc = cyc + 1; e.busy_cycles = 0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset abort in cycle 3 of a multiply.
        issue(2'b01, 8'd200, 8'd150, 16'd0, 1'b0, 8, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dz", 32'(div_zero), 32'd0);
        start = 1'b1; opcode = 2'b00; A = 8'd9; B = 8'd9;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("abort_still_idle", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(2'b00, 8'd3, 8'd4, 16'd7, 1'b0, 0, 1'b1); drain();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
